// File: rtl/regfile_decode_if.sv
// Decode-stage bus for regfile_decode: instruction fields, writeback ports and registered operands.
interface regfile_decode_if #(parameter int WIDTH = 64);
  logic [3:0]       icode, rA, rB;
  logic             stall;
  logic [3:0]       dstE, dstM;
  logic [WIDTH-1:0] valE, valM;
  logic             wb_en;
  logic [WIDTH-1:0] valA, valB;
  logic [3:0]       srcA, srcB;

  modport master (
    output icode, rA, rB, stall, dstE, dstM, valE, valM, wb_en,
    input  valA, valB, srcA, srcB
  );
  modport slave (
    input  icode, rA, rB, stall, dstE, dstM, valE, valM, wb_en,
    output valA, valB, srcA, srcB
  );
endinterface

// File: rtl/regfile_decode.sv
// Register file with decode-stage operand selection and registered operand outputs.
// Optional macro REGFILE_BYPASS_EN forwards same-edge writeback data into valA/valB.
module regfile_decode #(
  parameter int WIDTH   = 64,
  parameter int NREG    = 15,
  parameter int RSP_IDX = 4
) (
  input logic         clk,
  input logic         rst_n,
  regfile_decode_if.slave rf
);
  localparam logic [3:0] NREG_L = 4'(NREG);
  localparam logic [3:0] RSP    = 4'(RSP_IDX);
  localparam logic [3:0] RNONE  = 4'hF;

  logic [WIDTH-1:0] regs [NREG];
  logic [3:0]       dec_a, dec_b;
  logic [WIDTH-1:0] rd_a, rd_b;

  always_comb begin
    dec_a = RNONE;
    dec_b = RNONE;
    case (rf.icode)
      4'd2, 4'd4, 4'd6, 4'd10: dec_a = rf.rA;
      4'd9, 4'd11:             dec_a = RSP;
      default:                 dec_a = RNONE;
    endcase
    case (rf.icode)
      4'd4, 4'd5, 4'd6:           dec_b = rf.rB;
      4'd8, 4'd9, 4'd10, 4'd11:   dec_b = RSP;
      default:                    dec_b = RNONE;
    endcase
  end

  // Indices at or above NREG (including 4'hF) read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (dec_a < NREG_L) rd_a = regs[dec_a];
    if (dec_b < NREG_L) rd_b = regs[dec_b];
`ifdef REGFILE_BYPASS_EN
    if (rf.wb_en && dec_a < NREG_L) begin
      if (dec_a == rf.dstM)      rd_a = rf.valM;
      else if (dec_a == rf.dstE) rd_a = rf.valE;
    end
    if (rf.wb_en && dec_b < NREG_L) begin
      if (dec_b == rf.dstM)      rd_b = rf.valM;
      else if (dec_b == rf.dstE) rd_b = rf.valE;
    end
`endif
  end

  // Port M wins when both writeback ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rf.wb_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (rf.dstM == 4'(i))      regs[i] <= rf.valM;
        else if (rf.dstE == 4'(i)) regs[i] <= rf.valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf.valA <= '0;
      rf.valB <= '0;
      rf.srcA <= RNONE;
      rf.srcB <= RNONE;
    end else if (!rf.stall) begin
      rf.valA <= rd_a;
      rf.valB <= rd_b;
      rf.srcA <= dec_a;
      rf.srcB <= dec_b;
    end
  end
endmodule

// File: doc/regfile_decode.md
REGFILE_DECODE -- requirements
Module: regfile_decode

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data width of every register and value port.
REQ-002 SHALL have parameter NREG, default 15, meaning number of implemented registers (legal 2..15).
REQ-003 SHALL have parameter RSP_IDX, default 4, meaning index of the stack pointer register used for implicit operands.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port icode  input  4  instruction code of the instruction in decode.
REQ-007 SHALL have ports rA, rB  input  4 each  register specifier fields; 4'hF = none.
REQ-008 SHALL have port stall  input  1  hold decode outputs and suppress capture.
REQ-009 SHALL have ports dstE, dstM  input  4 each  writeback destinations; 4'hF = no write.
REQ-010 SHALL have ports valE, valM  input  WIDTH each  writeback data.
REQ-011 SHALL have port wb_en  input  1  qualifies both writeback ports.
REQ-012 SHALL have ports valA, valB  output  WIDTH each  registered decoded operands.
REQ-013 SHALL have ports srcA, srcB  output  4 each  registered decoded source indices.

Function
REQ-014 SHALL decode srcA = rA for icode 2,4,6,10; RSP_IDX for icode 9,11; 4'hF otherwise.
REQ-015 SHALL decode srcB = rB for icode 4,5,6; RSP_IDX for icode 8,9,10,11; 4'hF otherwise.
REQ-016 SHALL treat any source or destination index >= NREG (including 4'hF) as none: reads return zero, writes are discarded.
REQ-017 SHALL, on each rising edge with stall=0, capture decoded srcA/srcB and the corresponding register contents into srcA/srcB/valA/valB (one-cycle latency).
REQ-018 SHALL, with stall=1, hold valA, valB, srcA, srcB unchanged; writeback still proceeds.
REQ-019 SHALL, on each rising edge with wb_en=1, write valE to register dstE and valM to register dstM.
REQ-020 SHALL, when dstE == dstM (valid index) with wb_en=1, write valM only (port M has priority).
REQ-021 SHALL leave register contents unchanged when wb_en=0.
REQ-022 SHALL provide no other path modifying registers; icode values 12..15 decode as no sources.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear all NREG registers to zero.
REQ-024 SHALL, while rst_n=0, drive valA=0, valB=0, srcA=4'hF, srcB=4'hF.
REQ-025 SHALL, on reset asserted mid-operation, discard any same-edge writeback and capture.
REQ-026 SHALL resume normal capture on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-edge writeback data into valA/valB when srcA/srcB matches an active dstM or dstE (dstM priority).
REQ-028 SHALL, with REGFILE_BYPASS_EN undefined, capture the pre-write register value on a same-edge read/write collision.

Verification
REQ-029 SHALL cover: reset, write regs r[i]=i via dstE, icode=6 rA=3 rB=9 -> next cycle valA=3 valB=9 srcA=3 srcB=9.
REQ-030 SHALL cover: icode=11 (popq) rA=2, r4=0x100 -> valA=0x100 valB=0x100 srcA=4 srcB=4.
REQ-031 SHALL cover: wb_en=1 dstE=5 valE=0xAA dstM=5 valM=0xBB, then icode=2 rA=5 -> valA=0xBB.
REQ-032 SHALL cover: icode=6 rA=7 with same-edge dstE=7 valE=0x55 (old r7=7) -> valA=0x55 with REGFILE_BYPASS_EN, valA=7 without.
REQ-033 SHALL cover: stall=1 for 3 cycles while icode/rA change -> valA/valB/srcA/srcB unchanged; written registers visible after stall releases.
REQ-034 SHALL cover: rst_n pulsed low mid-cycle after writes -> outputs immediately 0/4'hF; subsequent icode=6 rA=3 rB=9 -> valA=0 valB=0.
